traffic_ctrl_gen2: RTL
======================

Name: traffic_ctrl_gen2

Overview:
Second-generation two-road traffic-light controller. Road A and road B each get a green, yellow, left-turn and yellow sequence, while the other road is held red. Every phase duration is a parameter, and the block counts down in whole seconds from an internal prescaler. New in this generation: all-red clearance on start-up, night flashing-yellow mode, pedestrian early-termination of green, and a red-road countdown showing total time until that road's green. Both countdowns are two-digit BCD and feed the 7-segment display driver.

Parameters:
CLK_DIV, 50_000_000, clk cycles per 1-second tick (min 2)
TG_A, 40, road A green seconds
TL_A, 15, road A left-turn seconds
TG_B, 30, road B green seconds
TL_B, 15, road B left-turn seconds
TY, 5, yellow seconds (both roads, both yellows)
TAR, 3, all-red clearance seconds
TPED, 5, green remaining after a pedestrian request
Constraint: all durations are 1..99, TPED < TG_A and TPED < TG_B, TAR+TG+TL+2*TY <= 99 per road. Elaboration fails otherwise.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  run enable; 0 = hold all-red
night  in  1  1 = flashing-yellow mode
ped_a  in  1  level request to end road A green early
ped_b  in  1  level request to end road B green early
lampa  out  4  road A lamps {red,yellow,green,left}: 1000 red, 0100 yellow, 0010 green, 0001 left
lampb  out  4  road B lamps, same encoding
acount  out  8  road A countdown, BCD {tens,units}
bcount  out  8  road B countdown, BCD
phase  out  4  current state code

Behaviour:
- States and phase codes: ALL_RED=0, A_G=1, A_Y1=2, A_L=3, A_Y2=4, B_G=5, B_Y1=6, B_L=7, B_Y2=8, FLASH=9.
- Internal registers: state, rem (7-bit binary seconds), div (prescaler), flash bit.
- Outputs are combinational decodes of the registers, so they update directly after the edge that changes the registers.
- Reset (async) and en=0 (sync, highest priority after rst):
  - state=ALL_RED, rem=TAR, div=0, flash=1.
  - lampa=lampb=1000, acount=bcount=8'h00, phase=0.
- Tick: div counts 0..CLK_DIV-1 while en=1. A tick is the cycle with div==CLK_DIV-1, after which div wraps to 0. The first tick occurs CLK_DIV cycles after en rises.
- Countdown (all states except FLASH), on a tick:
  - rem>1: rem decrements.
  - rem==1: advance to the next state and load its duration.
  - Each phase therefore displays N..1 for exactly N ticks.
- Sequence: ALL_RED(TAR) -> A_G(TG_A) -> A_Y1(TY) -> A_L(TL_A) -> A_Y2(TY) -> B_G(TG_B) -> B_Y1(TY) -> B_L(TL_B) -> B_Y2(TY) -> A_G.
  - ALL_RED is only entered from reset, en low, or night exit.
- Lamps:
  - Active road shows green/yellow/left per phase; the other road shows 1000.
  - ALL_RED: both roads 1000.
- Counts:
  - Active road: rem.
  - Red road: rem plus the durations of the remaining phases before its own green.
  - ALL_RED: acount=rem, bcount=rem+TG_A+TL_A+2*TY.
  - Binary-to-BCD conversion covers 0..99.
- Pedestrian:
  - In A_G with ped_a=1 and rem>TPED: rem<=TPED on that edge, and the decrement is suppressed if that edge is also a tick.
  - The same rule applies to B_G with ped_b.
  - Requests in any other state are ignored; there is no latching.
- Night:
  - night=1 with en=1: enter FLASH on the next edge from any state, with flash=1 and div=0.
  - In FLASH, flash toggles on each tick. Both lamps show 0100 when flash=1 and 0000 when flash=0. Both counts are 00.
  - night=0 while in FLASH: go to ALL_RED with rem=TAR and div=0.
- Priority: rst > en=0 > night > pedestrian truncation > tick.

Test Plan:
Use CLK_DIV=4, TG_A=5, TL_A=3, TG_B=4, TL_B=2, TY=2, TAR=1, TPED=2.
1. Start-up:
   - Stimulus: rst pulse, then en=1.
   - Required: phase 0, acount=01, bcount=13. After 4 cycles: phase 1, lampa=0010, lampb=1000, acount=05, bcount=12.
2. Full cycle:
   - Stimulus: run from A_G entry for 88 cycles.
   - Required: phases 1..8 each last duration*4 cycles, then phase 1 returns. In B_G entry: lampb=0010, bcount=04, acount=10.
3. Pedestrian:
   - Stimulus: ped_a=1 in A_G with acount=05.
   - Required: next edge gives acount=02, bcount=09. A_Y1 follows after 2 ticks. ped_a during B_G has no effect.
4. Night:
   - Stimulus: night=1 mid-A_L.
   - Required: next edge phase=9, lamps 0100/0100, counts 00. Lamps toggle 0000/0100 every 4 cycles. On night=0: phase 0, acount=01.
5. en drop:
   - Stimulus: en=0 mid-B_L.
   - Required: next edge phase=0, lamps 1000/1000, counts 00. Outputs stay there while en=0.
6. Async reset:
   - Stimulus: rst asserted between clock edges during A_Y2.
   - Required: outputs go all-red / 00 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/traffic_ctrl_gen2.sv
// Two-road traffic-light sequencer with all-red start-up, night flashing-yellow,
// pedestrian green truncation and BCD time-to-green countdowns for both roads.
module traffic_ctrl_gen2 #(
  parameter int CLK_DIV = 50_000_000,
  parameter int TG_A    = 40,
  parameter int TL_A    = 15,
  parameter int TG_B    = 30,
  parameter int TL_B    = 15,
  parameter int TY      = 5,
  parameter int TAR     = 3,
  parameter int TPED    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       night,
  input  logic       ped_a,
  input  logic       ped_b,
  output logic [3:0] lampa,
  output logic [3:0] lampb,
  output logic [7:0] acount,
  output logic [7:0] bcount,
  output logic [3:0] phase
);

  if (CLK_DIV < 2 ||
      TG_A < 1 || TG_A > 99 || TL_A < 1 || TL_A > 99 ||
      TG_B < 1 || TG_B > 99 || TL_B < 1 || TL_B > 99 ||
      TY < 1 || TY > 99 || TAR < 1 || TAR > 99 || TPED < 1 || TPED > 99 ||
      TPED >= TG_A || TPED >= TG_B ||
      TAR + TG_A + TL_A + 2 * TY > 99 ||
      TAR + TG_B + TL_B + 2 * TY > 99) begin : g_bad_params
    $error("traffic_ctrl_gen2: parameter set out of range");
  end

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [6:0] R_TGA  = 7'(TG_A);
  localparam logic [6:0] R_TLA  = 7'(TL_A);
  localparam logic [6:0] R_TGB  = 7'(TG_B);
  localparam logic [6:0] R_TLB  = 7'(TL_B);
  localparam logic [6:0] R_TY   = 7'(TY);
  localparam logic [6:0] R_TAR  = 7'(TAR);
  localparam logic [6:0] R_TPED = 7'(TPED);

  localparam logic [3:0] LAMP_RED  = 4'b1000;
  localparam logic [3:0] LAMP_YEL  = 4'b0100;
  localparam logic [3:0] LAMP_GRN  = 4'b0010;
  localparam logic [3:0] LAMP_LEFT = 4'b0001;
  localparam logic [3:0] LAMP_OFF  = 4'b0000;

  typedef enum logic [3:0] {
    ALL_RED = 4'd0,
    A_G     = 4'd1,
    A_Y1    = 4'd2,
    A_L     = 4'd3,
    A_Y2    = 4'd4,
    B_G     = 4'd5,
    B_Y1    = 4'd6,
    B_L     = 4'd7,
    B_Y2    = 4'd8,
    FLASH   = 4'd9
  } state_t;

  state_t           state, state_nxt;
  logic [6:0]       rem, rem_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             flash, flash_nxt;
  logic             active;
  logic             tick;
  logic             ped_cut;
  logic [6:0]       a_bin, b_bin;

  function automatic state_t succ(input state_t s);
    case (s)
      ALL_RED: succ = A_G;
      A_G:     succ = A_Y1;
      A_Y1:    succ = A_L;
      A_L:     succ = A_Y2;
      A_Y2:    succ = B_G;
      B_G:     succ = B_Y1;
      B_Y1:    succ = B_L;
      B_L:     succ = B_Y2;
      B_Y2:    succ = A_G;
      default: succ = ALL_RED;
    endcase
  endfunction

  function automatic logic [6:0] dur_of(input state_t s);
    case (s)
      A_G:                     dur_of = R_TGA;
      A_L:                     dur_of = R_TLA;
      B_G:                     dur_of = R_TGB;
      B_L:                     dur_of = R_TLB;
      A_Y1, A_Y2, B_Y1, B_Y2:  dur_of = R_TY;
      default:                 dur_of = R_TAR;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign tick    = (div == DIV_LAST);
  assign ped_cut = ((state == A_G && ped_a) || (state == B_G && ped_b)) && (rem > R_TPED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ALL_RED;
      rem    <= R_TAR;
      div    <= '0;
      flash  <= 1'b1;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      div    <= div_nxt;
      flash  <= flash_nxt;
      active <= en;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    div_nxt   = div;
    flash_nxt = flash;
    if (!en) begin
      state_nxt = ALL_RED;
      rem_nxt   = R_TAR;
      div_nxt   = '0;
      flash_nxt = 1'b1;
    end else if (night) begin
      if (state != FLASH) begin
        state_nxt = FLASH;
        div_nxt   = '0;
        flash_nxt = 1'b1;
      end else begin
        div_nxt = tick ? '0 : div + 1'b1;
        if (tick) flash_nxt = ~flash;
      end
    end else if (state == FLASH) begin
      state_nxt = ALL_RED;
      rem_nxt   = R_TAR;
      div_nxt   = '0;
      flash_nxt = 1'b1;
    end else begin
      div_nxt = tick ? '0 : div + 1'b1;
      // A pedestrian cut takes the whole edge, so a coinciding tick is not counted.
      if (ped_cut) begin
        rem_nxt = R_TPED;
      end else if (tick) begin
        if (rem > 7'd1) begin
          rem_nxt = rem - 7'd1;
        end else begin
          state_nxt = succ(state);
          rem_nxt   = dur_of(succ(state));
        end
      end
    end
  end

  // Red-road count = own remaining time plus every phase left before its green.
  always_comb begin
    lampa = LAMP_RED;
    lampb = LAMP_RED;
    a_bin = '0;
    b_bin = '0;
    case (state)
      ALL_RED: begin
        a_bin = rem;
        b_bin = rem + R_TGA + R_TLA + R_TY + R_TY;
      end
      A_G: begin
        lampa = LAMP_GRN;
        a_bin = rem;
        b_bin = rem + R_TY + R_TLA + R_TY;
      end
      A_Y1: begin
        lampa = LAMP_YEL;
        a_bin = rem;
        b_bin = rem + R_TLA + R_TY;
      end
      A_L: begin
        lampa = LAMP_LEFT;
        a_bin = rem;
        b_bin = rem + R_TY;
      end
      A_Y2: begin
        lampa = LAMP_YEL;
        a_bin = rem;
        b_bin = rem;
      end
      B_G: begin
        lampb = LAMP_GRN;
        b_bin = rem;
        a_bin = rem + R_TY + R_TLB + R_TY;
      end
      B_Y1: begin
        lampb = LAMP_YEL;
        b_bin = rem;
        a_bin = rem + R_TLB + R_TY;
      end
      B_L: begin
        lampb = LAMP_LEFT;
        b_bin = rem;
        a_bin = rem + R_TY;
      end
      B_Y2: begin
        lampb = LAMP_YEL;
        b_bin = rem;
        a_bin = rem;
      end
      FLASH: begin
        lampa = flash ? LAMP_YEL : LAMP_OFF;
        lampb = flash ? LAMP_YEL : LAMP_OFF;
      end
      default: begin
        lampa = LAMP_RED;
        lampb = LAMP_RED;
      end
    endcase
  end

  // Counts blank while held off or just reset, until en has been seen on an edge.
  assign acount = active ? to_bcd(a_bin) : 8'h00;
  assign bcount = active ? to_bcd(b_bin) : 8'h00;
  assign phase  = state;

endmodule
